// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared widths, iteration count and FSM state encoding for the divider sequencer
package div_sequencer_pkg;

  localparam int DW_DEFAULT   = 8;
  localparam int ITER_DEFAULT = DW_DEFAULT + 1;
  localparam int CNT_W        = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SUB     = 3'd2,
    S_RESTORE = 3'd3,
    S_SHIFT   = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_e;

endpackage

// File: rtl/div_iter_counter.sv
// rtl/div_iter_counter.sv - iteration counter with clear/increment and last-iteration flag
module div_iter_counter
  import div_sequencer_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic inc_i,
  output logic last_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == CNT_LAST);

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - control FSM for the restoring shift-subtract divider
// Optional: DIV_OVERFLOW_CHECK_EN rejects divisions whose quotient cannot fit in DW bits.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] divisor,
  input  logic [DW-1:0] dividend_hi,
  input  logic          alu_borrow,
  output logic          load_divisor,
  output logic          load_dividend,
  output logic          mux_sel,
  output logic          alu_sub,
  output logic          clear_quot,
  output logic          shift_quot_left,
  output logic          shift_div_right,
  output logic          quot_bit,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int ITER = DW + 1;

  state_e state_q, state_d;
  logic   quot_bit_q, quot_bit_d;
  logic   cnt_clear, cnt_inc, cnt_last;
  logic   overflow;

`ifdef DIV_OVERFLOW_CHECK_EN
  assign overflow = (dividend_hi >= divisor);
`else
  logic unused_dividend_hi;
  assign unused_dividend_hi = ^dividend_hi;
  assign overflow = 1'b0;
`endif

  div_iter_counter #(
    .ITER(ITER)
  ) u_counter (
    .clk    (clk),
    .rst_ni (reset),
    .clear_i(cnt_clear),
    .inc_i  (cnt_inc),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d         = state_q;
    quot_bit_d      = quot_bit_q;
    cnt_clear       = 1'b0;
    cnt_inc         = 1'b0;
    load_divisor    = 1'b0;
    load_dividend   = 1'b0;
    mux_sel         = 1'b0;
    alu_sub         = 1'b0;
    clear_quot      = 1'b0;
    shift_quot_left = 1'b0;
    shift_div_right = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    error           = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (divisor == '0 || overflow) begin
            state_d = S_ERR;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        load_divisor  = 1'b1;
        load_dividend = 1'b1;
        mux_sel       = 1'b1;
        clear_quot    = 1'b1;
        cnt_clear     = 1'b1;
        state_d       = S_SUB;
      end
      // Trial subtract; a borrow means the divisor did not fit this bit position.
      S_SUB: begin
        alu_sub       = 1'b1;
        load_dividend = 1'b1;
        if (alu_borrow) begin
          state_d = S_RESTORE;
        end else begin
          quot_bit_d = 1'b1;
          state_d    = S_SHIFT;
        end
      end
      S_RESTORE: begin
        load_dividend = 1'b1;
        quot_bit_d    = 1'b0;
        state_d       = S_SHIFT;
      end
      S_SHIFT: begin
        shift_quot_left = 1'b1;
        shift_div_right = 1'b1;
        cnt_inc         = 1'b1;
        if (cnt_last) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SUB;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done    = 1'b1;
        error   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      quot_bit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      quot_bit_q <= quot_bit_d;
    end
  end

  assign quot_bit = quot_bit_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - random and directed checks of div_sequencer driving a behavioural divider datapath
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  divisor = 8'h00;
  logic [7:0]  dividend_hi = 8'h00;
  logic [7:0]  dividend_lo = 8'h00;
  logic        alu_borrow;
  logic        load_divisor, load_dividend, mux_sel, alu_sub, clear_quot;
  logic        shift_quot_left, shift_div_right, quot_bit, busy, done, error;

  logic [15:0] m_div = 16'h0000;
  logic [15:0] m_rem = 16'h0000;
  logic [7:0]  m_quot = 8'h00;
  logic [15:0] alu_res;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DIV_OVERFLOW_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  div_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .divisor        (divisor),
    .dividend_hi    (dividend_hi),
    .alu_borrow     (alu_borrow),
    .load_divisor   (load_divisor),
    .load_dividend  (load_dividend),
    .mux_sel        (mux_sel),
    .alu_sub        (alu_sub),
    .clear_quot     (clear_quot),
    .shift_quot_left(shift_quot_left),
    .shift_div_right(shift_div_right),
    .quot_bit       (quot_bit),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Datapath the sequencer steers: divisor, remainder and quotient registers plus ALU.
  assign alu_res    = alu_sub ? (m_rem - m_div) : (m_rem + m_div);
  assign alu_borrow = (m_rem < m_div);

  always @(posedge clk) begin
    if (load_divisor) m_div <= {divisor, 8'h00};
    else if (shift_div_right) m_div <= m_div >> 1;
    if (load_dividend) m_rem <= mux_sel ? {dividend_hi, dividend_lo} : alu_res;
    if (clear_quot) m_quot <= 8'h00;
    else if (shift_quot_left) m_quot <= {m_quot[6:0], quot_bit};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] all_outs();
    return {load_divisor, load_dividend, mux_sel, alu_sub, clear_quot, shift_quot_left,
            shift_div_right, quot_bit, busy, done, error};
  endfunction

  // Arithmetic reference: quotient mod 256, exact remainder, one restore per zero bit of 9.
  function automatic void ref_div(input logic [15:0] dvd, input logic [7:0] dsr, output bit err,
                                  output logic [7:0] q, output logic [7:0] r, output int lat);
    int tq;
    err = (dsr == 8'h00) || (OVF_EN && (dvd[15:8] >= dsr));
    q = 8'h00;
    r = 8'h00;
    lat = 1;
    if (!err) begin
      tq  = int'(dvd) / int'(dsr);
      q   = tq[7:0];
      r   = 8'(int'(dvd) % int'(dsr));
      lat = 20 + 9 - $countones(tq[8:0]);
    end
  endfunction

  task automatic run_div(input string tag, input logic [15:0] dvd, input logic [7:0] dsr,
                         input bit hold, input int pulse_at);
    bit         err_e;
    logic [7:0] q_e, r_e;
    int         lat_e;
    int         done_c = -1;
    int         loads = 0;
    logic       err_o = 1'b0;
    logic       busy_o = 1'b0;
    logic       idle_busy = 1'b0;
    ref_div(dvd, dsr, err_e, q_e, r_e, lat_e);
    @(negedge clk);
    {dividend_hi, dividend_lo} = dvd;
    divisor = dsr;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 60 && done_c < 0; c++) begin
      @(negedge clk);
      start = hold || (c == pulse_at);
      if (load_divisor || load_dividend) loads++;
      if (done) begin
        done_c = c;
        err_o  = error;
        busy_o = busy;
      end
    end
    check({tag, ".latency"}, done_c, lat_e);
    check({tag, ".error"}, err_o, err_e);
    check({tag, ".busy_at_done"}, busy_o, 1'b1);
    if (err_e) begin
      check({tag, ".no_loads"}, loads, 0);
    end else begin
      check({tag, ".quotient"}, m_quot, q_e);
      check({tag, ".remainder"}, m_rem, {8'h00, r_e});
    end
    if (!hold) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        idle_busy = idle_busy | busy;
      end
      check({tag, ".idle_after"}, idle_busy, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] dvd;
    logic [7:0]  dsr;
    int          max_d;
    int          shifts;
    int          done_c;
    logic        saw_done;

    repeat (3) @(negedge clk);
    check("reset.outputs", all_outs(), 11'h0);
    reset = 1'b1;
    @(negedge clk);
    check("reset.idle", all_outs(), 11'h0);

    run_div("t1_100_7", 16'h0064, 8'h07, 1'b0, 0);
    run_div("t2_1234_12", 16'h1234, 8'h12, 1'b0, 0);
    run_div("t3_div0", 16'hBEEF, 8'h00, 1'b0, 0);
    run_div("t4_ff_ff", 16'h00FF, 8'hFF, 1'b0, 0);
    run_div("t4_ff_01", 16'h00FF, 8'h01, 1'b0, 0);

    // Abort with reset during the SHIFT of the fourth iteration.
    @(negedge clk);
    {dividend_hi, dividend_lo} = 16'h0064;
    divisor = 8'h07;
    start = 1'b1;
    @(posedge clk);
    shifts = 0;
    for (int c = 0; c < 60 && shifts < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (shift_quot_left) shifts++;
    end
    check("t5.reached_shift4", shifts, 4);
    #1 reset = 1'b0;
    #1 check("t5.async_outputs", all_outs(), 11'h0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check("t5.no_done", saw_done, 1'b0);
    run_div("t5_after", 16'h0064, 8'h07, 1'b0, 0);

    run_div("t6_pulse", 16'h0064, 8'h07, 1'b0, 5);

    // Back-to-back: start held through DONE gives one IDLE cycle then LOAD.
    run_div("t6_b2b_a", 16'h0064, 8'h07, 1'b1, 0);
    @(negedge clk);
    check("t6_b2b.idle_gap", busy, 1'b0);
    @(negedge clk);
    check("t6_b2b.load", load_divisor, 1'b1);
    start = 1'b0;
    done_c = -1;
    for (int c = 2; c <= 60 && done_c < 0; c++) begin
      @(negedge clk);
      if (done) done_c = c;
    end
    check("t6_b2b.latency", done_c, 26);
    check("t6_b2b.quotient", m_quot, 8'h0E);
    check("t6_b2b.remainder", m_rem, 16'h0002);

    for (int i = 0; i < 24; i++) begin
      dsr = (i % 6 == 5) ? 8'h00 : 8'($urandom_range(1, 255));
      max_d = (dsr == 8'h00) ? 65535 : int'(dsr) * 512 - 1;
      if (max_d > 65535) max_d = 65535;
      dvd = 16'($urandom_range(0, max_d));
      run_div($sformatf("rand%0d", i), dvd, dsr, 1'b0, (i % 4 == 0) ? 7 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
